// File: rtl/timer_driver.sv
// Command-side controller for the 8-bit countdown timer: sequences power-on, config commit and stop,
// and reports expiry/done/arm-timeout. Optional `TIMER_DRIVER_EXP_CNT_EN adds a saturating expire counter.
module timer_driver #(
  parameter int ARM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic       cmd_mode,
  input  logic [7:0] cmd_value,
  output logic       tmr_on,
  output logic       tmr_off,
  output logic       tmr_ok,
  output logic       tmr_mode,
  output logic [7:0] tmr_value,
  input  logic [7:0] tmr_out,
  output logic       busy,
  output logic       expire,
  output logic       done,
  output logic       err
`ifdef TIMER_DRIVER_EXP_CNT_EN
  ,
  output logic [7:0] exp_cnt
`endif
);

  localparam int CW = $clog2(ARM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PWR, S_ARM, S_OK, S_BLANK, S_RUN, S_FIN, S_STOP
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   arm_cnt, arm_cnt_nxt;
  logic            err_nxt;
  logic            expire_nxt;
  logic            done_nxt;
  logic            accept, start_acc, stop_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      arm_cnt   <= '0;
      tmr_on    <= 1'b0;
      tmr_off   <= 1'b0;
      tmr_ok    <= 1'b0;
      tmr_mode  <= 1'b0;
      tmr_value <= 8'h00;
      busy      <= 1'b0;
      expire    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state   <= state_nxt;
      arm_cnt <= arm_cnt_nxt;
      tmr_on  <= (state_nxt == S_PWR);
      tmr_off <= (state_nxt == S_STOP);
      tmr_ok  <= (state_nxt == S_OK);
      busy    <= (state_nxt != S_IDLE);
      expire  <= expire_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      if (start_acc) begin
        tmr_mode  <= cmd_mode;
        tmr_value <= cmd_value;
      end
    end
  end

  // A stop always beats a simultaneous tmr_out==00, so a late stop never yields a spurious expire.
  always_comb begin
    cmd_ready   = 1'b0;
    state_nxt   = state;
    arm_cnt_nxt = arm_cnt;
    err_nxt     = err;
    expire_nxt  = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      S_IDLE:                 cmd_ready = 1'b1;
      S_ARM, S_RUN, S_FIN:    cmd_ready = cmd_op;
      default:                cmd_ready = 1'b0;
    endcase
    accept    = cmd_valid & cmd_ready;
    start_acc = accept & ~cmd_op;
    stop_acc  = accept & cmd_op;
    case (state)
      S_IDLE: begin
        if (start_acc) begin
          err_nxt   = 1'b0;
          state_nxt = S_PWR;
        end
      end
      S_PWR: begin
        arm_cnt_nxt = '0;
        state_nxt   = S_ARM;
      end
      S_ARM: begin
        if (stop_acc) begin
          state_nxt = S_STOP;
        end else if (tmr_out == 8'h00) begin
          state_nxt = S_OK;
        end else begin
          arm_cnt_nxt = arm_cnt + CW'(1);
          if (arm_cnt_nxt == CW'(ARM_TIMEOUT)) begin
            err_nxt   = 1'b1;
            state_nxt = S_STOP;
          end
        end
      end
      S_OK:    state_nxt = S_BLANK;
      S_BLANK: state_nxt = S_RUN;
      S_RUN: begin
        if (stop_acc) begin
          state_nxt = S_STOP;
        end else if (tmr_out == 8'h00) begin
          expire_nxt = 1'b1;
          if (!tmr_mode) state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        if (stop_acc) begin
          state_nxt = S_STOP;
        end else if (tmr_out == 8'hFF) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_STOP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef TIMER_DRIVER_EXP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_cnt <= 8'h00;
    end else if (start_acc) begin
      exp_cnt <= 8'h00;
    end else if (expire_nxt && (exp_cnt != 8'hFF)) begin
      exp_cnt <= exp_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_timer_driver.sv
// Scoreboarded bench for timer_driver: a scripted timer waveform predicts the driver's pulse events,
// which a negedge monitor pops and compares as they appear.
module tb_timer_driver;

  localparam int ARM_TO = 16;
  localparam logic [4:0] EV_ON = 5'b10000, EV_OFF = 5'b01000, EV_OK = 5'b00100,
                         EV_EXP = 5'b00010, EV_DONE = 5'b00001;

  logic       clk, reset;
  logic       cmd_valid, cmd_ready, cmd_op, cmd_mode;
  logic [7:0] cmd_value;
  logic       tmr_on, tmr_off, tmr_ok, tmr_mode;
  logic [7:0] tmr_value, tmr_out;
  logic       busy, expire, done, err;
`ifdef TIMER_DRIVER_EXP_CNT_EN
  logic [7:0] exp_cnt;
`endif

  timer_driver #(.ARM_TIMEOUT(ARM_TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_mode(cmd_mode), .cmd_value(cmd_value),
    .tmr_on(tmr_on), .tmr_off(tmr_off), .tmr_ok(tmr_ok),
    .tmr_mode(tmr_mode), .tmr_value(tmr_value), .tmr_out(tmr_out),
    .busy(busy), .expire(expire), .done(done), .err(err)
`ifdef TIMER_DRIVER_EXP_CNT_EN
    , .exp_cnt(exp_cnt)
`endif
  );

  typedef struct {
    int         cyc;
    logic [4:0] mask;
    logic       err_e;
    logic       busy_e;
    logic       mode_e;
    logic [7:0] value_e;
  } ev_t;

  ev_t  sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   model_err = 0;
  int   exp_count = 0;
  logic [4:0] obs;
  ev_t  cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int at, input logic [4:0] mask, input logic busy_e,
                         input logic mode_e, input logic [7:0] value_e);
    ev_t e;
    e.cyc = at; e.mask = mask; e.err_e = model_err; e.busy_e = busy_e;
    e.mode_e = mode_e; e.value_e = value_e;
    sb.push_back(e);
  endtask

  task automatic check_cnt(input int expv);
`ifdef TIMER_DRIVER_EXP_CNT_EN
    checkOutput("exp_cnt", exp_cnt, expv);
`else
    if (expv < 0) $display("[TB] negative expire count %0d", expv);
`endif
  endtask

  // Stop presented in the current cycle: off pulse next cycle, idle the cycle after.
  task automatic issue_stop(input string name);
    cmd_valid = 1'b1; cmd_op = 1'b1;
    #1;
    checkOutput(name, cmd_ready, 1'b1);
    push_ev(cyc + 1, EV_OFF, 1'b1, 1'b0, 8'h00);
    tick();
    cmd_valid = 1'b0;
    tmr_out = 8'hFF;
    tick();
    checkOutput("busy_after_stop", busy, 1'b0);
    check_cnt(exp_count);
  endtask

  // One start transaction against a scripted timer waveform derived from the timer's documented behaviour.
  task automatic applyStimulus(input bit mode, input int value, input int warm, input int stop_arm,
                               input int stop_run, input int fin_delay, input int reset_run,
                               input bit busy_probe);
    int t;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_mode = mode; cmd_value = value[7:0];
    #1;
    checkOutput("ready_start_idle", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    model_err = 0;
    exp_count = 0;
    push_ev(cyc, EV_ON, 1'b1, 1'b0, 8'h00);
    tmr_out = 8'hFF;
    for (int i = 0; i < warm; i++) begin
      tick();
      tmr_out = 8'hFF;
      if (i == stop_arm) begin
        issue_stop("ready_stop_arm");
        return;
      end
      if (i == ARM_TO - 1) begin
        model_err = 1;
        push_ev(cyc + 1, EV_OFF, 1'b1, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("err_set_idle", {busy, err}, 2'b01);
        repeat (3) tick();
        checkOutput("err_sticky", err, 1'b1);
        return;
      end
    end
    tick();
    tmr_out = 8'h00;
    push_ev(cyc + 1, EV_OK, 1'b1, mode, value[7:0]);
    tick();
    tmr_out = 8'h00;
    tick();
    tmr_out = 8'h00;
    for (int k = 0; k < 400; k++) begin
      tick();
      t = mode ? value - (k % (value + 1)) : value - k;
      tmr_out = t[7:0];
      if (busy_probe && k == 0) begin
        cmd_valid = 1'b1; cmd_op = 1'b0;
        #1;
        checkOutput("ready_start_busy", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
      end
      if (k == reset_run) begin
        reset = 1'b1;
        check_cnt(exp_count);
        tick();
        checkOutput("outputs_after_reset",
                    {tmr_on, tmr_off, tmr_ok, tmr_mode, tmr_value, busy, expire, done, err}, 16'h0);
        check_cnt(0);
        reset = 1'b0;
        tmr_out = 8'hFF;
        model_err = 0;
        return;
      end
      if (k == stop_run) begin
        issue_stop("ready_stop_run");
        return;
      end
      if (t == 0) begin
        push_ev(cyc + 1, EV_EXP, 1'b1, 1'b0, 8'h00);
        if (exp_count < 255) exp_count++;
        if (!mode) break;
      end
    end
    for (int d = 0; d < fin_delay; d++) begin
      tick();
      tmr_out = 8'h00;
    end
    tick();
    tmr_out = 8'hFF;
    push_ev(cyc + 1, EV_DONE, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("idle_after_done", {busy, err}, 2'b00);
    check_cnt(exp_count);
  endtask

  // Monitor: every cycle with any pulse output high consumes the oldest expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      obs = {tmr_on, tmr_off, tmr_ok, expire, done};
      if (obs != 5'b0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_event", {59'd0, obs}, 64'd0);
        end else begin
          cur = sb.pop_front();
          checkOutput("event_cycle", cyc, cur.cyc);
          checkOutput("event_fields",
                      {obs, err, busy, tmr_ok ? tmr_mode : 1'b0, tmr_ok ? tmr_value : 8'h00},
                      {cur.mask, cur.err_e, cur.busy_e, cur.mode_e, cur.value_e});
        end
      end
    end
  end

  initial begin
    bit m;
    int v, w, sa, sr;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_mode = 1'b0; cmd_value = 8'h00;
    tmr_out = 8'hFF;
    repeat (3) tick();
    checkOutput("reset_state",
                {tmr_on, tmr_off, tmr_ok, tmr_mode, tmr_value, busy, expire, done, err}, 16'h0);
    reset = 1'b0;
    mon_en = 1;
    tick();

    applyStimulus(1'b0, 3, 3, -1, -1, 0, -1, 1'b0);
    applyStimulus(1'b1, 2, 2, -1, 12, 0, -1, 1'b1);
    applyStimulus(1'b0, 4, ARM_TO, -1, -1, 0, -1, 1'b0);
    applyStimulus(1'b0, 1, 0, -1, -1, 2, -1, 1'b0);
    applyStimulus(1'b1, 3, 1, -1, 3, 0, -1, 1'b0);
    applyStimulus(1'b0, 2, 5, 2, -1, 0, -1, 1'b0);

    cmd_valid = 1'b1; cmd_op = 1'b1;
    #1;
    checkOutput("ready_stop_idle", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    checkOutput("idle_after_idle_stop", busy, 1'b0);

    applyStimulus(1'b1, 0, 1, -1, -1, 0, 5, 1'b0);
    tick();

    for (int n = 0; n < 25; n++) begin
      m  = $urandom_range(0, 1);
      v  = $urandom_range(0, 5);
      w  = $urandom_range(0, 17);
      sa = ($urandom_range(0, 4) == 0 && w > 0) ? $urandom_range(0, w - 1) : -1;
      if (m) sr = $urandom_range(0, 14);
      else   sr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, v) : -1;
      applyStimulus(m, v, w, sa, sr, $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (4) tick();
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_driver.md
Name: timer_driver

Overview:
- Command-side controller for the 8-bit countdown timer. It converts start/stop commands into the timer's on/off/ok/mode/value control pulses, monitors the timer's 8-bit status output, and reports expiry, completion and arm-timeout events upstream.
- Sits between a command source (valid/ready) and one timer instance; both share the same clock and reset.

Parameters:
- ARM_TIMEOUT, 16, maximum cycles spent in ARM waiting for tmr_out==8'h00 before flagging err.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid&cmd_ready (combinational of state and cmd_op)
- cmd_op  input  1  0=start, 1=stop
- cmd_mode  input  1  start: 0=one-shot, 1=periodic
- cmd_value  input  8  start: reload/count value
- tmr_on  output  1  registered; one-cycle power-on pulse to timer
- tmr_off  output  1  registered; one-cycle shutdown pulse to timer
- tmr_ok  output  1  registered; one-cycle configuration-commit pulse
- tmr_mode  output  1  latched mode, valid while tmr_ok=1
- tmr_value  output  8  latched value, valid while tmr_ok=1
- tmr_out  input  8  timer status: 8'hFF=off/warming, 8'h00=awaiting config/setting/expired, else count
- busy  output  1  high in every state except IDLE
- expire  output  1  one-cycle pulse per detected expiry
- done  output  1  one-cycle pulse when a one-shot run completes
- err  output  1  sticky arm-timeout flag; cleared by the next accepted start or by reset

Behaviour:
- Reset: state=IDLE; tmr_on/off/ok=0; tmr_mode=0; tmr_value=0; busy/expire/done/err=0; arm counter=0.
- States: IDLE, PWR, ARM, OK, BLANK, RUN, FIN, STOP. All outputs registered except cmd_ready.
- cmd_ready: 1 in IDLE for any op; 1 in ARM/RUN/FIN only when cmd_op=1; 0 otherwise. A start command while busy is never accepted.
- IDLE: start accepted -> latch mode/value, clear err, go to PWR. Stop accepted -> no-op, stay in IDLE.
- PWR: tmr_on=1 for this single cycle; clear arm counter; go to ARM.
- ARM: each cycle, if tmr_out==8'h00, go to OK. Else increment the arm counter. When the counter reaches ARM_TIMEOUT, set err=1 and go to STOP.
- OK: tmr_ok=1 with tmr_mode/tmr_value driven for exactly one cycle; go to BLANK.
- BLANK: one cycle; the timer's setting cycle shows 8'h00 and is not counted as an expiry. Go to RUN.
- RUN:
  - tmr_out==8'h00 -> expire=1 on the next cycle.
  - If the mode is one-shot, go to FIN; if periodic, stay in RUN.
  - Periodic with value=0 produces expire every cycle.
- FIN: wait for tmr_out==8'hFF, then pulse done=1 and go to IDLE.
- STOP: tmr_off=1 for one cycle; go to IDLE. done is not asserted.
- An accepted stop in ARM/RUN/FIN goes to STOP on the next cycle.
- Stop accepted in the same cycle as tmr_out==8'h00 in RUN: the stop wins and no expire is generated.
- Latency, start accept to tmr_on: 1 cycle. tmr_ok follows the first tmr_out==00 in ARM by 1 cycle.
- Reset mid-operation forces IDLE and all outputs to their reset values immediately. No off pulse is issued; the timer shares the same reset.

Optional Feature:
- Macro: TIMER_DRIVER_EXP_CNT_EN.
- Defined:
  - Adds output exp_cnt[7:0]: a saturating count of expire pulses since the last accepted start.
  - Cleared to 0 on reset and on each accepted start; holds at 8'hFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then start mode=0 value=3; model timer out FF,FF,FF,00,00,03,02,01,00,FF -> tmr_on 1 cycle after accept, tmr_ok with value=3, a single expire, done after FF, busy low, err=0.
- Start mode=1 value=2; run 12 cycles of the timer model -> expire every 3 cycles, no done, busy stays high; then stop -> tmr_off one cycle, IDLE.
- Start with tmr_out held at FF for ARM_TIMEOUT=16 cycles -> err=1 sticky, tmr_off pulse, IDLE, tmr_ok never asserted; next start clears err.
- In RUN, assert stop in the same cycle tmr_out==00 -> no expire, tmr_off next cycle, done=0.
- Start while busy (cmd_op=0 in RUN) -> cmd_ready=0, command not consumed; stop in IDLE -> cmd_ready=1, no output activity.
- Periodic value=0 for 5 cycles with TIMER_DRIVER_EXP_CNT_EN defined -> expire every cycle, exp_cnt=5; assert reset mid-run -> all outputs 0 and exp_cnt=0 the next cycle.
